// File: rtl/kgp_risc_pkg.sv
// Shared ISA constants, ALU encodings and decode-stage FSM encoding for the KGP RISC core.
package kgp_risc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h01;
   localparam logic [5:0] OP_LW    = 6'h02;
   localparam logic [5:0] OP_SW    = 6'h03;
   localparam logic [5:0] OP_J     = 6'h05;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [3:0] ALU_NONE = 4'h0;
   localparam logic [3:0] ALU_ADD  = 4'h2;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_HALT   = 2'd2
   } state_t;

   // Everything the decode stage needs from one instruction word.
   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] imm_ext;
      logic [3:0]  alu_op;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        is_jump;
      logic        is_halt;
      logic        is_load;
      logic        reads_rt;
   } ctrl_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: splits the word into fields and control bits.
module instr_decoder
   import kgp_risc_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 32
) (
   input  logic [INSTR_W-1:0] instr,
   output ctrl_t              dec,
   output logic [PC_W-1:0]    jump_target
);

   logic [5:0] opcode;

   assign opcode      = instr[31:26];
   assign jump_target = instr[PC_W-1:0];

   always_comb begin
      dec           = '0;
      dec.rs        = instr[25:21];
      dec.rt        = instr[20:16];
      dec.imm_ext   = sign_ext16(instr[15:0]);
      dec.alu_op    = ALU_NONE;
      case (opcode)
         OP_RTYPE: begin
            dec.alu_op    = instr[3:0];
            dec.reg_write = 1'b1;
            dec.reads_rt  = 1'b1;
         end
         OP_ADDI: begin
            dec.alu_op    = ALU_ADD;
            dec.reg_write = 1'b1;
         end
         OP_LW: begin
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
            dec.is_load   = 1'b1;
         end
         OP_SW: begin
            dec.mem_write = 1'b1;
            dec.reads_rt  = 1'b1;
         end
         OP_J:    dec.is_jump = 1'b1;
         OP_HALT: dec.is_halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: run/bubble/halt FSM, load-use hazard tracker and registered decode outputs.
module decode_stage
   import kgp_risc_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic [PC_W-1:0]    next_PC,
   input  logic               if_valid,
   output logic               PC_select,
   output logic [PC_W-1:0]    branch_PC,
   output logic               stall_if,
   output logic               id_valid,
   output logic [4:0]         rs_addr,
   output logic [4:0]         rt_addr,
   output logic [31:0]        imm_ext,
   output logic [3:0]         alu_op,
   output logic               reg_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic [PC_W-1:0]    id_PC,
   output logic               halted,
   output state_t             fsm_state
);

   state_t          state, state_next;
   ctrl_t           dec;
   logic [PC_W-1:0] jump_target;
   logic [4:0]      ld_rt;
   logic            hazard;
   logic            accept;

   instr_decoder #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_dec (
      .instr       (instr),
      .dec         (dec),
      .jump_target (jump_target)
   );

   // ld_rt holds the destination of the last accepted LW; zero means no pending load.
   always_comb begin
      hazard = 1'b0;
      if (state == ST_RUN && if_valid && ld_rt != 5'd0)
         hazard = (dec.rs == ld_rt) || (dec.reads_rt && dec.rt == ld_rt);
   end

   // Combinational outputs are gated by rst so they read 0 the instant reset asserts.
   assign accept    = rst && state == ST_RUN && if_valid && !hazard;
   assign stall_if  = rst && (state == ST_HALT || hazard);
   assign PC_select = accept && dec.is_jump;
   assign branch_PC = PC_select ? jump_target : '0;
   assign halted    = (state == ST_HALT);
   assign fsm_state = state;

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            if (accept && dec.is_jump)      state_next = ST_BUBBLE;
            else if (accept && dec.is_halt) state_next = ST_HALT;
         end
         ST_BUBBLE: state_next = ST_RUN;
         ST_HALT:   state_next = ST_HALT;
         default:   state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_RUN;
      else      state <= state_next;
   end

   // The stall cycle covers the load latency, so the tracker clears as it stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         ld_rt <= 5'd0;
      else if (hazard)  ld_rt <= 5'd0;
      else if (accept)  ld_rt <= dec.is_load ? dec.rt : 5'd0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_valid  <= 1'b0;
         rs_addr   <= 5'd0;
         rt_addr   <= 5'd0;
         imm_ext   <= 32'd0;
         alu_op    <= ALU_NONE;
         reg_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         id_PC     <= '0;
      end else if (accept) begin
         id_valid  <= 1'b1;
         rs_addr   <= dec.rs;
         rt_addr   <= dec.rt;
         imm_ext   <= dec.imm_ext;
         alu_op    <= dec.alu_op;
         reg_write <= dec.reg_write;
         mem_read  <= dec.mem_read;
         mem_write <= dec.mem_write;
         id_PC     <= next_PC;
      end else begin
         // Fields hold; only the strobes drop so nothing downstream acts.
         id_valid  <= 1'b0;
         reg_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

endmodule
